stopwatch_display: RTL and testbench

Display back-end for the stopwatch. It consumes the binary `minutes`/`seconds`/`status` outputs of `stopwatch_top`. It converts them to BCD with a sequential shift-add-3 converter and drives a 4-digit, active-low, time-multiplexed 7-segment display showing MM.SS. The display blinks while the stopwatch is paused.

---
 rtl/stopwatch_pkg.sv | 29 ++
 rtl/stopwatch_display_bin2bcd.sv | 47 ++++
 rtl/stopwatch_display.sv | 142 ++++++++++++++
 tb/tb_stopwatch_display.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display path: status encodings,
// seven-segment table, converter states and small BCD helpers.
package stopwatch_pkg;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_PAUSE = 2'b10;

   localparam int NUM_DIGITS = 4;

   // Active-low cathodes, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_TABLE [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic {CONV_IDLE, CONV_RUN} conv_state_t;

   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      seg_encode = (d <= 4'd9) ? SEG_TABLE[d] : SEG_BLANK;
   endfunction

   // Any value with a nonzero hundreds digit shows as 99
   function automatic logic [7:0] sat99(input logic [11:0] bcd);
      sat99 = (bcd[11:8] != 4'd0) ? 8'h99 : bcd[7:0];
   endfunction

endpackage

// File: rtl/stopwatch_display_bin2bcd.sv
// Iterative 8-bit to 3-digit BCD converter (shift-add-3), one step per cycle.
// done is high during the final step; result is valid in that same cycle.
module bin2bcd_seq
   import stopwatch_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  bin,
   output logic        done,
   output logic [11:0] result
);

   logic [19:0] sh;
   logic [19:0] adj;
   logic [19:0] step;
   logic [2:0]  cnt;
   logic        active;

   always_comb begin
      adj = sh;
      if (sh[11:8]  >= 4'd5) adj[11:8]  = sh[11:8]  + 4'd3;
      if (sh[15:12] >= 4'd5) adj[15:12] = sh[15:12] + 4'd3;
      if (sh[19:16] >= 4'd5) adj[19:16] = sh[19:16] + 4'd3;
      step = adj << 1;
   end

   assign done   = active && (cnt == 3'd7);
   assign result = step[19:8];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh     <= '0;
         cnt    <= '0;
         active <= 1'b0;
      end else if (start && !active) begin
         sh     <= {12'd0, bin};
         cnt    <= '0;
         active <= 1'b1;
      end else if (active) begin
         sh  <= step;
         cnt <= cnt + 3'd1;
         if (cnt == 3'd7) active <= 1'b0;
      end
   end

endmodule

// File: rtl/stopwatch_display.sv
// Stopwatch display back-end: BCD conversion of MM:SS and a blinking,
// time-multiplexed 4-digit active-low 7-segment driver.
//
// state     | meaning
// CONV_IDLE | waiting for {minutes,seconds} to differ from the captured pair
// CONV_RUN  | 8 shift-add-3 steps in flight; inputs ignored until commit
module stopwatch_display
   import stopwatch_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  minutes,
   input  logic [5:0]  seconds,
   input  logic [1:0]  status,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        dp,
   output logic [15:0] digits,
   output logic        busy
);

   localparam int RW = $clog2(REFRESH_DIV);
   localparam int BW = $clog2(BLINK_DIV);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);

   conv_state_t   state;
   logic [7:0]    cap_min;
   logic [5:0]    cap_sec;
   logic          changed;
   logic          start;
   logic          m_done;
   logic          s_done;
   logic [11:0]   m_res;
   logic [11:0]   s_res;

   logic [RW-1:0] rcnt;
   logic [IW-1:0] idx;
   logic [IW-1:0] idx_nx;
   logic [BW-1:0] bcnt;
   logic [BW-1:0] bcnt_nx;
   logic          blank;
   logic          blank_nx;
   logic          paused;
   logic [3:0]    nib;
   logic [3:0]    an_nx;

   assign changed = ({minutes, seconds} != {cap_min, cap_sec});
   assign start   = (state == CONV_IDLE) && changed;

   bin2bcd_seq u_min (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .bin    (minutes),
      .done   (m_done),
      .result (m_res)
   );

   bin2bcd_seq u_sec (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .bin    ({2'b00, seconds}),
      .done   (s_done),
      .result (s_res)
   );

   // Outputs are registered from next-cycle index/phase so an and seg switch together
   always_comb begin
      case (status)
         ST_PAUSE:        paused = 1'b1;
         ST_IDLE, ST_RUN: paused = 1'b0;
         default:         paused = 1'b0;
      endcase
      idx_nx = (rcnt == R_LAST) ? idx + 1'b1 : idx;
      if (!paused) begin
         bcnt_nx  = '0;
         blank_nx = 1'b0;
      end else if (bcnt == B_LAST) begin
         bcnt_nx  = '0;
         blank_nx = ~blank;
      end else begin
         bcnt_nx  = bcnt + 1'b1;
         blank_nx = blank;
      end
      case (idx_nx)
         IW'(0):  begin nib = digits[3:0];   an_nx = 4'b1110; end
         IW'(1):  begin nib = digits[7:4];   an_nx = 4'b1101; end
         IW'(2):  begin nib = digits[11:8];  an_nx = 4'b1011; end
         default: begin nib = digits[15:12]; an_nx = 4'b0111; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= CONV_IDLE;
         cap_min <= '0;
         cap_sec <= '0;
         digits  <= '0;
         busy    <= 1'b0;
         rcnt    <= '0;
         idx     <= '0;
         bcnt    <= '0;
         blank   <= 1'b0;
         seg     <= SEG_BLANK;
         an      <= 4'hF;
         dp      <= 1'b1;
      end else begin
         rcnt  <= (rcnt == R_LAST) ? '0 : rcnt + 1'b1;
         idx   <= idx_nx;
         bcnt  <= bcnt_nx;
         blank <= blank_nx;
         seg   <= seg_encode(nib);
         an    <= blank_nx ? 4'hF : an_nx;
         dp    <= !((idx_nx == IW'(2)) && !blank_nx);
         case (state)
            CONV_IDLE: begin
               if (start) begin
                  cap_min <= minutes;
                  cap_sec <= seconds;
                  busy    <= 1'b1;
                  state   <= CONV_RUN;
               end
            end
            CONV_RUN: begin
               if (m_done && s_done) begin
                  digits <= {sat99(m_res), sat99(s_res)};
                  busy   <= 1'b0;
                  state  <= CONV_IDLE;
               end
            end
            default: state <= CONV_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench for stopwatch_display: expected BCD values are queued when
// inputs are driven and checked when each conversion commits.
module tb_stopwatch_display;
   import stopwatch_pkg::*;

   localparam int REFRESH_DIV = 4;
   localparam int BLINK_DIV   = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  minutes;
   logic [5:0]  seconds;
   logic [1:0]  status;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        dp;
   logic [15:0] digits;
   logic        busy;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [15:0] exp_q[$];
   logic [15:0] last_digits = 16'h0000;

   always #5 clk = ~clk;

   stopwatch_display #(
      .REFRESH_DIV (REFRESH_DIV),
      .BLINK_DIV   (BLINK_DIV)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .minutes (minutes),
      .seconds (seconds),
      .status  (status),
      .seg     (seg),
      .an      (an),
      .dp      (dp),
      .digits  (digits),
      .busy    (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at the negedge where new inputs were driven
   task automatic run_conv(input string tag);
      int          waitc = 0;
      int          hi = 0;
      logic [15:0] e;
      @(negedge clk);
      while (!busy && waitc < 20) begin
         waitc++;
         @(negedge clk);
      end
      chk({tag, " start latency"}, waitc, 0);
      while (busy && hi < 20) begin
         chk({tag, " digits held"}, digits, last_digits);
         hi++;
         @(negedge clk);
      end
      chk({tag, " busy length"}, hi, 8);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      chk({tag, " digits"}, digits, e);
      last_digits = e;
   endtask

   initial begin
      logic [3:0] an_tab [4];
      logic [6:0] seg_tab [4];
      logic [3:0] prev;
      logic       found;
      logic       blank;

      an_tab  = '{4'hE, 4'hD, 4'hB, 4'h7};
      seg_tab = '{7'h19, 7'h30, 7'h24, 7'h79};
      minutes = 8'd12;
      seconds = 6'd34;
      status  = ST_RUN;

      // Reset held three cycles
      repeat (3) begin
         @(negedge clk);
         chk("reset seg", seg, 7'h7F);
         chk("reset an", an, 4'hF);
         chk("reset digits", digits, 16'h0000);
         chk("reset busy", busy, 1'b0);
      end
      rst_n = 1'b1;
      exp_q.push_back(16'h1234);
      run_conv("conv 12:34");

      // Scan sequence
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         prev = an;
         @(negedge clk);
         if (prev == 4'h7 && an == 4'hE) found = 1'b1;
      end
      chk("scan sync", found, 1'b1);
      for (int i = 0; i < 16; i++) begin
         chk("scan an", an, an_tab[i/4]);
         chk("scan seg", seg, seg_tab[i/4]);
         chk("scan dp", dp, (i/4 == 2) ? 1'b0 : 1'b1);
         @(negedge clk);
      end

      // Saturation and out-of-range seconds
      minutes = 8'd150;
      seconds = 6'd59;
      exp_q.push_back(16'h9959);
      run_conv("conv 150:59");
      minutes = 8'd0;
      seconds = 6'd63;
      exp_q.push_back(16'h0063);
      run_conv("conv 0:63");

      // Change during conversion is ignored, then recaptured
      minutes = 8'd5;
      seconds = 6'd0;
      exp_q.push_back(16'h0500);
      fork
         run_conv("conv 05:00");
         begin
            repeat (3) @(negedge clk);
            seconds = 6'd1;
            exp_q.push_back(16'h0501);
         end
      join
      run_conv("conv 05:01");

      // Blink while paused
      status = ST_PAUSE;
      for (int n = 1; n <= 56; n++) begin
         @(negedge clk);
         blank = ((n / 16) % 2) == 1;
         chk($sformatf("blink an n=%0d", n), (an == 4'hF), blank);
         if (blank) chk("blink dp", dp, 1'b1);
      end
      status = ST_RUN;
      @(negedge clk);
      chk("unpause an", (an != 4'hF), 1'b1);

      // Reset in the middle of a conversion
      status  = ST_IDLE;
      minutes = 8'd42;
      seconds = 6'd7;
      repeat (3) @(negedge clk);
      chk("midconv busy", busy, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort busy", busy, 1'b0);
      chk("abort digits", digits, 16'h0000);
      chk("abort an", an, 4'hF);
      chk("abort seg", seg, 7'h7F);
      chk("abort dp", dp, 1'b1);
      last_digits = 16'h0000;
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(16'h4207);
      run_conv("reconv 42:07");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
